lcd_bus_sched: RTL and testbench
================================

# lcd_bus_sched

Sequencer and two-port arbiter for the shared character-LCD bus (HD44780-style E/RS/RW/DATA). It runs the power-on initialisation command sequence, then grants the bus to two requesters (e.g. text-line writer and status/score writer) one byte at a time. It generates the E strobe with fixed setup, pulse and hold phases, and inserts the long settle wait required after clear/home commands. It sits between the game/display logic and the LCD pins, replacing free-running E=clk drive.

## Interface
- INIT_WAIT, 70: idle cycles after reset release before the first init command (1..65535)
- TXN_CYCLES, 4: cycles per bus transaction, including setup and hold (3..15)
- LONG_WAIT, 200: extra idle cycles after a clear (0x01) or home (0x02) command (1..65535)

- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- req0  in  1  port 0 request; held high with rs0/data0 stable until ack0
- rs0  in  1  port 0 register select (0 = command, 1 = data)
- data0  in  8  port 0 byte
- ack0  out  1  one-cycle pulse: port 0 byte accepted
- req1, rs1, data1, ack1: same as port 0, for port 1
- ready  out  1  block in IDLE, init complete, bus free
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; always 0 (write-only)
- lcd_data  out  8  LCD data bus

## Operation
- States: RST_WAIT, INIT_CMD, IDLE, XFER, LONG.
- RST_WAIT: count INIT_WAIT cycles, then go to INIT_CMD with init index 0.
- INIT_CMD: issue four command transactions (rs=0) in order: 0x3C, 0x06, 0x0C, 0x01.
  - The last command (0x01) is followed by LONG, then IDLE.
- IDLE: ready=1, lcd_e=0; lcd_rs/lcd_data hold their last values.
- Acceptance: when req0 or req1 is sampled high, latch the winner's rs/data, pulse its ack for one cycle and go to XFER.
- Arbitration is round-robin. The rr pointer resets to port 0. On a simultaneous request, the port not granted last wins. A lone request wins immediately.
- Requests are ignored outside IDLE; no queueing. A requester keeps req high until it sees ack. Dropping req before ack withdraws the request.
- XFER: drive the latched byte for TXN_CYCLES cycles, then go to IDLE.
  - Exception: if rs=0 and data is 0x01 or 0x02, go to LONG (LONG_WAIT cycles), then IDLE.
- Long detection applies identically to init and requester commands.
- lcd_rw is constant 0 after reset.

## Timing
- Reset values (asserted asynchronously on resetn low):
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00
  - ack0=ack1=0, ready=0
  - state=RST_WAIT, rr pointer=port 0
- Reset mid-transaction: abort immediately; the full init sequence restarts on release.
- Transaction from edge n (acceptance or init issue):
  - After edge n: lcd_rs/lcd_data valid, lcd_e=0 (setup), ack pulse high (requester writes only).
  - After edges n+1 .. n+TXN_CYCLES-2: lcd_e=1.
  - After edge n+TXN_CYCLES-1: lcd_e=0 (hold).
  - After edge n+TXN_CYCLES: IDLE or LONG.
- lcd_rs/lcd_data are stable throughout a transaction and while lcd_e=1.
- ready falls in the same cycle as the ack pulse. Throughput is one byte per TXN_CYCLES cycles, with no idle gap between back-to-back grants.
- ready first rises INIT_WAIT + 4·TXN_CYCLES + LONG_WAIT cycles after reset release (286 cycles at defaults).
- Internal counter: 16 bits, compared with ==. It reloads to 0 on every state change and never wraps.

## Configuration
- LCD_BUS_SCHED_INIT_EN defined: RST_WAIT and INIT_CMD are implemented as above.
- Not defined:
  - Reset goes directly to IDLE; ready=1 in the first cycle after reset release.
  - INIT_WAIT is unused; requesters must issue the init commands themselves.
  - Long-command handling still applies.

## Test plan
- Reset release, no requests → exactly four E pulses carrying 0x3C, 0x06, 0x0C, 0x01 (rs=0); ready rises 286 cycles after release; lcd_rw=0 throughout.
- req0 (rs=1, data=0x48) in IDLE → ack0 one cycle; lcd_data=0x48, lcd_rs=1; lcd_e high for 2 cycles; ready back after 4 cycles.
- req0 and req1 held continuously with different bytes, rr pointer at reset value → grants alternate 0,1,0,1; each ack a single cycle; no gap between transactions.
- req1 (rs=0, data=0x01) → transaction followed by 200 cycles with ready=0; a req0 asserted during the wait is acked only after the wait ends. A command 0x80 sees no wait.
- resetn low mid-XFER with lcd_e=1 → lcd_e, ack and ready drop immediately; after release the init sequence replays in full.
- Build without LCD_BUS_SCHED_INIT_EN → ready=1 one cycle after reset release; no init E pulses; a first req0 is served immediately.

Source files
------------

// File: rtl/lcd_bus_sched.sv
// HD44780-style LCD bus scheduler: init sequencer, 2-port round-robin arbiter, E timing.
// Define LCD_BUS_SCHED_INIT_EN to run the power-on command sequence after reset.
module lcd_bus_sched #(
   parameter int INIT_WAIT  = 70,
   parameter int TXN_CYCLES = 4,
   parameter int LONG_WAIT  = 200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req0,
   input  logic       rs0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic       rs1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       ready,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam logic [2:0] RST_WAIT = 3'd0;
   localparam logic [2:0] INIT_CMD = 3'd1;
   localparam logic [2:0] IDLE     = 3'd2;
   localparam logic [2:0] XFER     = 3'd3;
   localparam logic [2:0] LONG     = 3'd4;

   localparam logic [15:0] TXN_LAST  = 16'(TXN_CYCLES - 1);
   localparam logic [15:0] LONG_LAST = 16'(LONG_WAIT - 1);

   logic [2:0]  state, state_n;
   logic [15:0] cnt, cnt_n;
   logic        rr, rr_n;
   logic        rs_n;
   logic [7:0]  data_n;
   logic        gnt0, gnt1;
   logic        take, pick1, last, is_long, txn_n;

`ifdef LCD_BUS_SCHED_INIT_EN
   localparam logic [15:0] INIT_LAST = 16'(INIT_WAIT - 1);

   logic [1:0] idx, idx_n;

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    init_byte = 8'h3C;
         2'd1:    init_byte = 8'h06;
         2'd2:    init_byte = 8'h0C;
         default: init_byte = 8'h01;
      endcase
   endfunction
`endif

   assign lcd_rw  = 1'b0;
   assign last    = (cnt == TXN_LAST);
   assign is_long = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
   // rr high means port 1 is favoured on a tie
   assign pick1   = req1 && (!req0 || rr);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 16'd1;
      rr_n    = rr;
      rs_n    = lcd_rs;
      data_n  = lcd_data;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      take    = 1'b0;
`ifdef LCD_BUS_SCHED_INIT_EN
      idx_n   = idx;
`endif
      unique case (state)
         RST_WAIT: begin
`ifdef LCD_BUS_SCHED_INIT_EN
            if (cnt == INIT_LAST) begin
               state_n = INIT_CMD;
               cnt_n   = '0;
               idx_n   = 2'd0;
               rs_n    = 1'b0;
               data_n  = init_byte(2'd0);
            end
`else
            state_n = IDLE;
            cnt_n   = '0;
`endif
         end
`ifdef LCD_BUS_SCHED_INIT_EN
         INIT_CMD: begin
            if (last) begin
               cnt_n = '0;
               if (idx == 2'd3) begin
                  state_n = is_long ? LONG : IDLE;
               end else begin
                  idx_n  = idx + 2'd1;
                  data_n = init_byte(idx + 2'd1);
               end
            end
         end
`endif
         IDLE: begin
            cnt_n = '0;
            take  = 1'b1;
         end
         XFER: begin
            if (last) begin
               cnt_n = '0;
               if (is_long) begin
                  state_n = LONG;
               end else begin
                  state_n = IDLE;
                  take    = 1'b1;
               end
            end
         end
         LONG: begin
            if (cnt == LONG_LAST) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = RST_WAIT;
            cnt_n   = '0;
         end
      endcase
      // Grant straight out of a finished transfer keeps the bus gap-free
      if (take && (req0 || req1)) begin
         gnt1    = pick1;
         gnt0    = !pick1;
         rr_n    = !pick1;
         state_n = XFER;
         cnt_n   = '0;
         rs_n    = pick1 ? rs1 : rs0;
         data_n  = pick1 ? data1 : data0;
      end
   end

   assign txn_n = (state_n == XFER) || (state_n == INIT_CMD);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= RST_WAIT;
         cnt      <= '0;
         rr       <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
         lcd_e    <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         ready    <= 1'b0;
`ifdef LCD_BUS_SCHED_INIT_EN
         idx      <= 2'd0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rr       <= rr_n;
         lcd_rs   <= rs_n;
         lcd_data <= data_n;
         lcd_e    <= txn_n && (cnt_n != 16'd0) && (cnt_n != TXN_LAST);
         ack0     <= gnt0;
         ack1     <= gnt1;
         ready    <= (state_n == IDLE);
`ifdef LCD_BUS_SCHED_INIT_EN
         idx      <= idx_n;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed testbench for lcd_bus_sched: init, single write, round-robin,
// long-command wait, mid-transfer reset.
module tb_lcd_bus_sched;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req0 = 1'b0, rs0 = 1'b0;
   logic       req1 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, ready, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lcd_bus_sched dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
      .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
      .ready(ready), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   task automatic wait_ready(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (lcd_e !== 1'b0 || lcd_rw !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_e_rw: got e=%b rw=%b want 0 0", lcd_e, lcd_rw);
      end
      n_checks++;
      if (lcd_rs !== 1'b0 || lcd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_bus: got rs=%b d=%h want 0 00", lcd_rs, lcd_data);
      end
      n_checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ack: got %b%b want 00", ack0, ack1);
      end
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 0", ready);
      end
      resetn = 1'b1;
   endtask

   // Entered right after resetn rises at a negedge
   task automatic test_startup;
`ifdef LCD_BUS_SCHED_INIT_EN
      int rdy_at = -1;
      int np = 0;
      logic [7:0] pd[4];
      logic prs[4];
      logic pe = 1'b0;
      bit rw_bad = 1'b0;
      logic [7:0] want;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         if (lcd_rw !== 1'b0) rw_bad = 1'b1;
         if (lcd_e === 1'b1 && pe !== 1'b1) begin
            if (np < 4) begin
               pd[np]  = lcd_data;
               prs[np] = lcd_rs;
            end
            np++;
         end
         pe = lcd_e;
         if (ready === 1'b1) begin
            rdy_at = k;
            break;
         end
      end
      n_checks++;
      if (rdy_at !== 286) begin
         n_fail++;
         $display("FAIL init_ready_at: got %0d want 286", rdy_at);
      end
      n_checks++;
      if (np !== 4) begin
         n_fail++;
         $display("FAIL init_pulses: got %0d want 4", np);
      end
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       want = 8'h3C;
            1:       want = 8'h06;
            2:       want = 8'h0C;
            default: want = 8'h01;
         endcase
         n_checks++;
         if (pd[i] !== want || prs[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL init_cmd%0d: got rs=%b d=%h want 0 %h",
                     i, prs[i], pd[i], want);
         end
      end
      n_checks++;
      if (rw_bad) begin
         n_fail++;
         $display("FAIL init_rw: got 1 want 0");
      end
`else
      int e_cnt = 0;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_first: got %b want 1", ready);
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (lcd_e !== 1'b0) e_cnt++;
      end
      n_checks++;
      if (e_cnt !== 0) begin
         n_fail++;
         $display("FAIL no_init_e: got %0d want 0", e_cnt);
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: got %b want 1", ready);
      end
`endif
   endtask

   task automatic test_single;
      bit ok;
      logic [0:4] e_exp = 5'b01100;
      logic [0:4] r_exp = 5'b00001;
      logic [0:4] a_exp = 5'b10000;
      wait_ready(400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_wait: got timeout want ready");
      end
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h48;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (lcd_e !== e_exp[k] || ready !== r_exp[k]) begin
            n_fail++;
            $display("FAIL single_c%0d: got e=%b rdy=%b want %b %b",
                     k, lcd_e, ready, e_exp[k], r_exp[k]);
         end
         n_checks++;
         if (ack0 !== a_exp[k] || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack%0d: got %b%b want %b0",
                     k, ack0, ack1, a_exp[k]);
         end
         n_checks++;
         if (lcd_data !== 8'h48 || lcd_rs !== 1'b1) begin
            n_fail++;
            $display("FAIL single_bus%0d: got rs=%b d=%h want 1 48",
                     k, lcd_rs, lcd_data);
         end
         if (k == 0) req0 = 1'b0;
      end
   endtask

   task automatic test_round_robin;
      int g = 0;
      int at[4];
      logic pt[4];
      logic [7:0] dt[4];
      int dbl = 0;
      logic p0 = 1'b0, p1 = 1'b0;
      bit ok;
      resetn = 1'b0;
      @(negedge clk);
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA0;
      req1 = 1'b1; rs1 = 1'b1; data1 = 8'hB1;
      resetn = 1'b1;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         if ((ack0 && p0) || (ack1 && p1) || (ack0 && ack1)) dbl++;
         p0 = ack0;
         p1 = ack1;
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            at[g] = k;
            pt[g] = ack1;
            dt[g] = lcd_data;
            g++;
            if (g == 4) break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      n_checks++;
      if (g !== 4) begin
         n_fail++;
         $display("FAIL rr_count: got %0d want 4", g);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (pt[i] !== logic'(i % 2) ||
             dt[i] !== ((i % 2 == 1) ? 8'hB1 : 8'hA0)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got port=%b d=%h want %0d",
                     i, pt[i], dt[i], i % 2);
         end
      end
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (at[i] - at[i-1] !== 4) begin
            n_fail++;
            $display("FAIL rr_gap%0d: got %0d want 4", i, at[i] - at[i-1]);
         end
      end
      n_checks++;
      if (dbl !== 0) begin
         n_fail++;
         $display("FAIL rr_ack_width: got %0d bad cycles want 0", dbl);
      end
      wait_ready(100, ok);
   endtask

   task automatic test_long;
      bit ok;
      bit got;
      int rdy_at = -1;
      int a0_at = -1;
      int k80 = -1;
      logic [7:0] d0 = 8'h00;
      wait_ready(400, ok);
      req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack1 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      req1 = 1'b0;
      n_checks++;
      if (!got || lcd_data !== 8'h01) begin
         n_fail++;
         $display("FAIL long_ack: got ack=%b d=%h want 1 01", got, lcd_data);
      end
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (ready === 1'b1 && rdy_at < 0) rdy_at = k;
         if (ack0 === 1'b1) begin
            a0_at = k;
            d0 = lcd_data;
            req0 = 1'b0;
            break;
         end
         if (k == 10) begin
            req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
         end
      end
      req0 = 1'b0;
      n_checks++;
      if (rdy_at !== 204) begin
         n_fail++;
         $display("FAIL long_ready_at: got %0d want 204", rdy_at);
      end
      n_checks++;
      if (a0_at !== 205 || d0 !== 8'h55) begin
         n_fail++;
         $display("FAIL long_req0: got at=%0d d=%h want 205 55", a0_at, d0);
      end
      wait_ready(50, ok);
      req1 = 1'b1; rs1 = 1'b0; data1 = 8'h80;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack1 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      req1 = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            k80 = k;
            break;
         end
      end
      n_checks++;
      if (!got || k80 !== 4) begin
         n_fail++;
         $display("FAIL cmd80_wait: got ack=%b ready_at=%0d want 1 4", got, k80);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      bit got = 1'b0;
      wait_ready(400, ok);
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h33;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack0 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      req0 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (!got || lcd_e !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: got ack=%b e=%b want 1 1", got, lcd_e);
      end
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (lcd_e !== 1'b0 || ack0 !== 1'b0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_drop: got e=%b ack=%b rdy=%b want 0 0 0",
                  lcd_e, ack0, ready);
      end
      n_checks++;
      if (lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_bus: got rs=%b d=%h want 0 00", lcd_rs, lcd_data);
      end
      @(negedge clk);
      resetn = 1'b1;
      test_startup();
   endtask

   initial begin
      test_reset();
      test_startup();
      test_single();
      test_round_robin();
      test_long();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
